// File: rtl/pe_ws_mac.sv
// rtl/pe_ws_mac.sv - weight-stationary MAC processing element with double-buffered weights
module pe_ws_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_swap,
  output logic [DATA_W-1:0] w_out,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  input  logic              sat_en,
  input  logic              clr_stats,
  output logic [31:0]       op_count,
  output logic              ovf_sticky
);

  if (ACC_W < 2 * DATA_W) begin : g_bad_width
    $error("pe_ws_mac: ACC_W must be at least 2*DATA_W");
  end

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0]        shadow;
  logic [DATA_W-1:0]        active;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    sum;
  logic                     ovf;
  logic [ACC_W-1:0]         result;
  logic [31:0]              cnt_next;

  assign w_out = shadow;

  // One guard bit above the accumulator catches overflow in either direction.
  always_comb begin
    prod = $signed(a_in) * $signed(active);
    sum  = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod}
         + {psum_in[ACC_W-1], psum_in};
    ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    if (sat_en && ovf) begin
      result = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      result = sum[ACC_W-1:0];
    end
    cnt_next = (op_count >= 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : op_count + 32'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      active         <= '0;
      a_out          <= '0;
      a_valid_out    <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      op_count       <= '0;
      ovf_sticky     <= 1'b0;
    end else begin
      a_out          <= a_in;
      a_valid_out    <= a_valid_in;
      psum_valid_out <= a_valid_in;
      if (w_load) shadow <= w_in;
      if (w_swap) active <= shadow;
      if (a_valid_in) psum_out <= result;
      // Clearing the stats wins over a same-cycle MAC.
      if (clr_stats) begin
        op_count   <= '0;
        ovf_sticky <= 1'b0;
      end else if (a_valid_in) begin
        op_count <= cnt_next;
        if (ovf) ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_ws_mac.sv
// tb/tb_pe_ws_mac.sv - self-checking bench for pe_ws_mac with a psum scoreboard
module tb_pe_ws_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        w_load = 1'b0;
  logic [15:0] w_in = '0;
  logic        w_swap = 1'b0;
  logic [15:0] w_out;
  logic [15:0] a_in = '0;
  logic        a_valid_in = 1'b0;
  logic [15:0] a_out;
  logic        a_valid_out;
  logic [31:0] psum_in = '0;
  logic [31:0] psum_out;
  logic        psum_valid_out;
  logic        sat_en = 1'b1;
  logic        clr_stats = 1'b0;
  logic [31:0] op_count;
  logic        ovf_sticky;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic signed [15:0] w_act;

  pe_ws_mac #(.DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_load(w_load), .w_in(w_in), .w_swap(w_swap), .w_out(w_out),
    .a_in(a_in), .a_valid_in(a_valid_in), .a_out(a_out), .a_valid_out(a_valid_out),
    .psum_in(psum_in), .psum_out(psum_out), .psum_valid_out(psum_valid_out),
    .sat_en(sat_en), .clr_stats(clr_stats), .op_count(op_count), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic signed [15:0] a, logic signed [15:0] w,
                                        logic signed [31:0] p, bit sat);
    longint s;
    s = longint'(a) * longint'(w) + longint'(p);
    if (sat && s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sat && s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_swap(logic [15:0] w);
    w_load = 1'b1; w_in = w;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    w_act = w;
  endtask

  task automatic mac(logic [15:0] a, logic [31:0] p, logic [31:0] expv);
    a_in = a; psum_in = p; a_valid_in = 1'b1;
    exp_q.push_back(expv);
    tick();
    a_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_out, a_out, a_valid_out, psum_out, psum_valid_out, op_count, ovf_sticky} !== '0)
      begin errors++; $display("FAIL reset_outputs: got psum=%h w=%h a=%h cnt=%h", psum_out, w_out, a_out, op_count); end
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (psum_valid_out !== 1'b0 || op_count !== 32'd0)
      begin errors++; $display("FAIL reset_idle: got valid=%b cnt=%h expected 0/0", psum_valid_out, op_count); end
  endtask

  task automatic test_load_swap_mac();
    w_load = 1'b1; w_in = 16'd3;
    tick();
    w_load = 1'b0;
    checks++;
    if (w_out !== 16'd3) begin errors++; $display("FAIL w_out_latency: got %h expected 0003", w_out); end
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    w_act = 16'sd3;
    mac(16'd5, 32'd10, 32'd25);
    checks++;
    if (psum_valid_out !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", psum_valid_out); end
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL first_mac: got %h expected %h", psum_out, e); end
    checks++;
    if (op_count !== 32'd2) begin errors++; $display("FAIL first_count: got %h expected 2", op_count); end
  endtask

  task automatic test_swap_load_same();
    w_load = 1'b1; w_in = 16'd7;
    tick();
    w_swap = 1'b1; w_in = 16'hFFFC;
    tick();
    w_swap = 1'b0; w_load = 1'b0;
    checks++;
    if (w_out !== 16'hFFFC) begin errors++; $display("FAIL swap_load_wout: got %h expected fffc", w_out); end
    mac(16'd2, 32'd0, 32'd14);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL swap_load_old_shadow: got %h expected %h", psum_out, e); end
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    mac(16'd2, 32'd0, 32'hFFFF_FFF8);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL second_swap: got %h expected %h", psum_out, e); end
    // MAC coinciding with a swap must still use the previous active weight.
    w_load = 1'b1; w_in = 16'd9;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    mac(16'd1, 32'd0, 32'hFFFF_FFFC);
    w_swap = 1'b0;
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL mac_during_swap: got %h expected %h", psum_out, e); end
    mac(16'd1, 32'd0, 32'd9);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL mac_after_swap: got %h expected %h", psum_out, e); end
  endtask

  task automatic test_saturation();
    load_swap(16'd32767);
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b expected 0", ovf_sticky); end
    sat_en = 1'b1;
    mac(16'd32767, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL sat_pos: got %h expected %h", psum_out, e); end
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf_sticky); end
    sat_en = 1'b0;
    mac(16'd32767, 32'h7FFF_FFFF, 32'hBFFF_0000);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL wrap_pos: got %h expected %h", psum_out, e); end
    load_swap(16'h8000);
    sat_en = 1'b1;
    mac(16'd32767, 32'h8000_0000, 32'h8000_0000);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL sat_neg: got %h expected %h", psum_out, e); end
  endtask

  task automatic test_signed_corner();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0 || op_count !== 32'd0)
      begin errors++; $display("FAIL clr_idle: got ovf=%b cnt=%h expected 0/0", ovf_sticky, op_count); end
    load_swap(16'hFFFE);
    mac(16'h8000, 32'hFFFF_FFFF, 32'd65535);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL signed_corner: got %h expected %h", psum_out, e); end
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL signed_no_ovf: got %b expected 0", ovf_sticky); end
  endtask

  task automatic test_counter_clear();
    logic [7:0]  pat;
    logic [15:0] a;
    logic [31:0] p;
    logic [31:0] last;
    pat = 8'b1101_0101;
    last = psum_out;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      p = $urandom;
      a_in = a; psum_in = p; a_valid_in = pat[i];
      if (pat[i]) begin
        last = model(a, w_act, p, sat_en);
        exp_q.push_back(last);
      end
      tick();
      checks++;
      if (a_out !== a) begin errors++; $display("FAIL a_out_delay[%0d]: got %h expected %h", i, a_out, a); end
      checks++;
      if (psum_valid_out !== pat[i]) begin errors++; $display("FAIL valid_pattern[%0d]: got %b expected %b", i, psum_valid_out, pat[i]); end
      checks++;
      if (pat[i]) begin
        e = exp_q.pop_front();
        if (psum_out !== e) begin errors++; $display("FAIL stream_mac[%0d]: got %h expected %h", i, psum_out, e); end
      end else if (psum_out !== last) begin
        errors++; $display("FAIL psum_hold[%0d]: got %h expected %h", i, psum_out, last);
      end
    end
    a_valid_in = 1'b0;
    checks++;
    if (op_count !== 32'd10) begin errors++; $display("FAIL op_count_10: got %h expected 0000000a", op_count); end
    sat_en = 1'b1;
    mac(16'h8000, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    void'(exp_q.pop_front());
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_before_clr: got %b expected 1", ovf_sticky); end
    sat_en = 1'b0; clr_stats = 1'b1;
    mac(16'h8000, 32'h7FFF_FFF0, 32'h8000_FFF0);
    clr_stats = 1'b0;
    checks++;
    if (op_count !== 32'd0 || ovf_sticky !== 1'b0)
      begin errors++; $display("FAIL clr_priority: got cnt=%h ovf=%b expected 0/0", op_count, ovf_sticky); end
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL clr_datapath: got %h expected %h", psum_out, e); end
    sat_en = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    a_in = 16'd100; psum_in = 32'd1000; a_valid_in = 1'b1;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({w_out, a_out, a_valid_out, psum_out, psum_valid_out, op_count, ovf_sticky} !== '0)
      begin errors++; $display("FAIL reset_async: got psum=%h a=%h cnt=%h valid=%b", psum_out, a_out, op_count, psum_valid_out); end
    a_valid_in = 1'b0;
    exp_q.delete();
    tick();
    #3 rst_n = 1'b1;
    tick();
    mac(16'd123, 32'd456, 32'd456);
    checks++;
    e = exp_q.pop_front();
    if (psum_out !== e) begin errors++; $display("FAIL post_reset_zero_weight: got %h expected %h", psum_out, e); end
    checks++;
    if (w_out !== 16'd0) begin errors++; $display("FAIL post_reset_shadow: got %h expected 0000", w_out); end
  endtask

  initial begin
    test_reset();
    test_load_swap_mac();
    test_swap_load_same();
    test_saturation();
    test_signed_corner();
    test_counter_clear();
    test_reset_mid_stream();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_ws_mac.md
# pe_ws_mac

Weight-stationary multiply-accumulate processing element for the NPU systolic array, generalised in data and accumulator width. It has these features:
- double-buffered weights, loaded through a vertical shift chain;
- a registered activation path to the right;
- a registered partial-sum path downward;
- a runtime saturate/wrap mode;
- a sticky overflow flag;
- a saturating operation counter.

One instance sits at each grid position. Rows chain activations and columns chain weights and partial sums.

## Interface
- DATA_W, 16: signed width of weights and activations.
- ACC_W, 32: signed width of partial sums. ACC_W >= 2*DATA_W is required, and elaboration fails otherwise.
- clk  in  1  single clock for the whole block, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_load  in  1  shift w_in into the shadow weight register.
- w_in  in  DATA_W  weight from the PE above (or the column loader).
- w_swap  in  1  copy the shadow weight to the active weight.
- w_out  out  DATA_W  shadow weight, feeding the w_in of the PE below.
- a_in  in  DATA_W  activation from the left.
- a_valid_in  in  1  a_in and psum_in are valid this cycle.
- a_out  out  DATA_W  registered activation to the right.
- a_valid_out  out  1  registered a_valid_in.
- psum_in  in  ACC_W  partial sum from above.
- psum_out  out  ACC_W  registered partial sum downward.
- psum_valid_out  out  1  psum_out was updated by the last MAC.
- sat_en  in  1  1 = saturate the result, 0 = two's-complement wrap.
- clr_stats  in  1  synchronous clear of op_count and ovf_sticky.
- op_count  out  32  integer-operation count.
- ovf_sticky  out  1  set when any MAC result exceeded the ACC_W range.

## Operation
- Weight load:
  - When w_load=1, shadow <= w_in.
  - w_out is the shadow register, so N cycles of w_load fill an N-deep column, with the bottom PE receiving the first word.
- Weight swap:
  - When w_swap=1, active <= shadow (the value held before this edge).
  - If w_swap and w_load are both high in the same cycle, active takes the old shadow and shadow takes w_in.
  - A MAC in the same cycle as w_swap uses the old active weight.
- MAC, when a_valid_in=1:
  - The product is a_in*active, full 2*DATA_W signed.
  - The product and psum_in are sign-extended to ACC_W+1 bits and summed.
  - Overflow is flagged when bits [ACC_W] and [ACC_W-1] of the sum differ.
- Result selection:
  - If sat_en=1 and the sum overflowed, psum_out <= 2^(ACC_W-1)-1 when the sum is positive, or -2^(ACC_W-1) when it is negative.
  - Otherwise psum_out <= sum[ACC_W-1:0].
- Valid flag: psum_valid_out <= a_valid_in.
  - When a_valid_in=0, psum_out holds its value and psum_valid_out goes to 0.
- Activation pass-through: every cycle, a_out <= a_in and a_valid_out <= a_valid_in, independent of weights and mode.
- Sticky overflow: ovf_sticky is set on any overflowing valid MAC, in either mode.
- Counter:
  - op_count adds 2 per valid MAC (one multiply, one add).
  - It saturates at 0xFFFFFFFF. When op_count is 0xFFFFFFFE, one more MAC gives 0xFFFFFFFF and the counter stays there.
- clr_stats:
  - When high, op_count <= 0 and ovf_sticky <= 0.
  - It has priority over a same-cycle MAC increment or overflow set.
  - It does not affect the data path.

## Timing
- Reset (rst_n=0, asynchronous and immediate) clears every register and output to 0:
  - shadow, active, w_out, a_out, a_valid_out, psum_out, psum_valid_out, op_count, ovf_sticky.
- Deassertion is synchronised externally. The first active edge after rst_n rises is a normal cycle.
- Reset during a load, swap or MAC stream discards all in-flight state, including both weight registers. The weights must be reloaded.
- Latency:
  - a_in to a_out: 1 cycle.
  - a_in/psum_in to psum_out: 1 cycle.
  - w_in to w_out: 1 cycle.
  - w_swap to the new weight being used: MAC on the next cycle.
- Throughput: one MAC per cycle with no stalls and no backpressure. The upstream array controller supplies the skew.
- sat_en and clr_stats are sampled per cycle, so changing sat_en affects only MACs from that edge onward.

## Test plan
- Load and swap, then MAC:
  - Stimulus: w_load with w_in=3, then w_swap, then a_in=5, psum_in=10, a_valid_in=1.
  - Required: psum_out=25 and psum_valid_out=1 one cycle later; w_out=3; op_count=2.
- Swap and load in the same cycle:
  - Stimulus: shadow=7, w_swap=1 and w_load=1 with w_in=-4, then MAC with a_in=2, psum_in=0.
  - Required: psum_out=14, w_out=-4. A further swap followed by the same MAC gives psum_out=-8.
- Saturation versus wrap (defaults):
  - Stimulus: active=32767, a_in=32767, psum_in=0x7FFFFFFF.
  - With sat_en=1: psum_out=0x7FFFFFFF and ovf_sticky=1.
  - With sat_en=0: psum_out=0xBFFF0000.
  - Negative case, active=-32768, a_in=32767, psum_in=0x80000000, sat_en=1: psum_out=0x80000000.
- Signed corner:
  - Stimulus: active=-2, a_in=-32768, psum_in=-1.
  - Required: psum_out=65535 and ovf_sticky stays 0.
- Counter and clear:
  - Stimulus: 5 valid MACs interleaved with 3 idle cycles.
  - Required: op_count=10, psum_valid_out low on the idle cycles, a_out tracking a_in with a 1-cycle delay.
  - Then clr_stats coincident with a valid MAC: op_count=0 and ovf_sticky=0, while psum_out still updates.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges during a MAC burst.
  - Required: all outputs go to 0 immediately, before the next edge. After release, MACs give psum_out=psum_in because the weight is 0.
